// File: rtl/tlb_walk_axi_reader.sv
// Single-outstanding AXI4 read engine shared by ITLB and DTLB page walks.
// One-deep pending slot per client, round-robin arbitration on contention, flush-aware responses.
module tlb_walk_axi_reader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TLB_FLUSH,
  input  logic              I_ADDR_TO_AXIM_VALID,
  input  logic [ADDR_W-1:0] I_ADDR_TO_AXIM,
  input  logic              D_ADDR_TO_AXIM_VALID,
  input  logic [ADDR_W-1:0] D_ADDR_TO_AXIM,
  output logic              I_DATA_FROM_AXIM_VALID,
  output logic [DATA_W-1:0] I_DATA_FROM_AXIM,
  output logic              D_DATA_FROM_AXIM_VALID,
  output logic [DATA_W-1:0] D_DATA_FROM_AXIM,
  output logic              I_WALK_ERR,
  output logic              D_WALK_ERR,
  output logic [ADDR_W-1:0] M_ARADDR,
  output logic              M_ARVALID,
  input  logic              M_ARREADY,
  output logic [7:0]        M_ARLEN,
  output logic [2:0]        M_ARSIZE,
  output logic [1:0]        M_ARBURST,
  input  logic [DATA_W-1:0] M_RDATA,
  input  logic [1:0]        M_RRESP,
  input  logic              M_RLAST,
  input  logic              M_RVALID,
  output logic              M_RREADY,
  output logic              OVERRUN
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_i_pend, r_d_pend;
  logic [ADDR_W-1:0]   r_i_addr, r_d_addr, r_araddr;
  logic                r_grant_d, r_rr_d, r_sup, r_overrun;
  logic                r_i_dv, r_d_dv, r_i_err, r_d_err;
  logic [DATA_W-1:0]   r_i_data, r_d_data;
  logic                w_arvalid, w_rready;

  // A client is busy while its own walk is on the bus, unless that walk was flushed.
  logic w_busy, w_i_busy, w_d_busy;
  assign w_busy   = (r_state != S_IDLE) && !r_sup;
  assign w_i_busy = w_busy && !r_grant_d;
  assign w_d_busy = w_busy && r_grant_d;

  logic w_i_in, w_d_in, w_i_drop, w_d_drop, w_i_acc, w_d_acc;
  assign w_i_in   = I_ADDR_TO_AXIM_VALID && !TLB_FLUSH;
  assign w_d_in   = D_ADDR_TO_AXIM_VALID && !TLB_FLUSH;
  assign w_i_drop = w_i_in && (r_i_pend || w_i_busy);
  assign w_d_drop = w_d_in && (r_d_pend || w_d_busy);
  assign w_i_acc  = w_i_in && !w_i_drop;
  assign w_d_acc  = w_d_in && !w_d_drop;

  // Fresh pulses join arbitration directly so ARVALID rises the cycle after the pulse.
  logic              w_i_req, w_d_req, w_gnt_d, w_grant;
  logic [ADDR_W-1:0] w_i_addr, w_d_addr;
  assign w_i_req  = !TLB_FLUSH && (r_i_pend || w_i_acc);
  assign w_d_req  = !TLB_FLUSH && (r_d_pend || w_d_acc);
  assign w_i_addr = r_i_pend ? r_i_addr : I_ADDR_TO_AXIM;
  assign w_d_addr = r_d_pend ? r_d_addr : D_ADDR_TO_AXIM;
  assign w_gnt_d  = w_d_req && (!w_i_req || r_rr_d);
  assign w_grant  = (r_state == S_IDLE) && (w_i_req || w_d_req);

  logic w_hs_r, w_err;
  assign w_hs_r = (r_state == S_R) && M_RVALID;
  assign w_err  = (M_RRESP != 2'b00) || !M_RLAST;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    case (r_state)
      S_IDLE: if (w_grant) w_state_nxt = S_AR;
      S_AR: begin
        w_arvalid = 1'b1;
        if (M_ARREADY) w_state_nxt = S_R;
      end
      S_R: begin
        w_rready = 1'b1;
        if (M_RVALID) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_i_pend  <= 1'b0;
      r_d_pend  <= 1'b0;
      r_i_addr  <= '0;
      r_d_addr  <= '0;
      r_araddr  <= '0;
      r_grant_d <= 1'b0;
      r_rr_d    <= 1'b0;
      r_sup     <= 1'b0;
      r_overrun <= 1'b0;
      r_i_dv    <= 1'b0;
      r_d_dv    <= 1'b0;
      r_i_err   <= 1'b0;
      r_d_err   <= 1'b0;
      r_i_data  <= '0;
      r_d_data  <= '0;
    end else begin
      r_i_dv   <= 1'b0;
      r_d_dv   <= 1'b0;
      r_i_err  <= 1'b0;
      r_d_err  <= 1'b0;
      r_i_data <= '0;
      r_d_data <= '0;
      if (w_hs_r && !(r_sup || TLB_FLUSH)) begin
        if (r_grant_d) begin
          r_d_dv   <= 1'b1;
          r_d_err  <= w_err;
          r_d_data <= w_err ? '0 : M_RDATA;
        end else begin
          r_i_dv   <= 1'b1;
          r_i_err  <= w_err;
          r_i_data <= w_err ? '0 : M_RDATA;
        end
      end
      if (w_hs_r)                                r_sup <= 1'b0;
      else if (TLB_FLUSH && r_state != S_IDLE)   r_sup <= 1'b1;
      if (w_grant) begin
        r_araddr  <= w_gnt_d ? w_d_addr : w_i_addr;
        r_grant_d <= w_gnt_d;
        if (w_i_req && w_d_req) r_rr_d <= !w_gnt_d;
      end
      if (TLB_FLUSH) begin
        r_i_pend <= 1'b0;
        r_d_pend <= 1'b0;
      end else begin
        if (w_grant && !w_gnt_d) r_i_pend <= 1'b0;
        else if (w_i_acc) begin
          r_i_pend <= 1'b1;
          r_i_addr <= I_ADDR_TO_AXIM;
        end
        if (w_grant && w_gnt_d) r_d_pend <= 1'b0;
        else if (w_d_acc) begin
          r_d_pend <= 1'b1;
          r_d_addr <= D_ADDR_TO_AXIM;
        end
      end
      if (w_i_drop || w_d_drop) r_overrun <= 1'b1;
    end
  end

  assign M_ARADDR               = r_araddr;
  assign M_ARVALID              = w_arvalid;
  assign M_RREADY               = w_rready;
  assign M_ARLEN                = 8'd0;
  assign M_ARSIZE               = 3'b010;
  assign M_ARBURST              = 2'b01;
  assign I_DATA_FROM_AXIM_VALID = r_i_dv;
  assign D_DATA_FROM_AXIM_VALID = r_d_dv;
  assign I_DATA_FROM_AXIM       = r_i_data;
  assign D_DATA_FROM_AXIM       = r_d_data;
  assign I_WALK_ERR             = r_i_err;
  assign D_WALK_ERR             = r_d_err;
  assign OVERRUN                = r_overrun;

endmodule

// File: tb/tb_tlb_walk_axi_reader.sv
// Directed bench for tlb_walk_axi_reader: inputs change and outputs are sampled 1ns after each rising edge.
module tb_tlb_walk_axi_reader;

  logic        CLK = 1'b0;
  logic        RST, TLB_FLUSH;
  logic        I_ADDR_TO_AXIM_VALID, D_ADDR_TO_AXIM_VALID;
  logic [31:0] I_ADDR_TO_AXIM, D_ADDR_TO_AXIM;
  logic        I_DATA_FROM_AXIM_VALID, D_DATA_FROM_AXIM_VALID;
  logic [31:0] I_DATA_FROM_AXIM, D_DATA_FROM_AXIM;
  logic        I_WALK_ERR, D_WALK_ERR;
  logic [31:0] M_ARADDR;
  logic        M_ARVALID, M_ARREADY;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE;
  logic [1:0]  M_ARBURST;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;
  logic        M_RLAST, M_RVALID, M_RREADY;
  logic        OVERRUN;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  tlb_walk_axi_reader #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .TLB_FLUSH(TLB_FLUSH),
    .I_ADDR_TO_AXIM_VALID(I_ADDR_TO_AXIM_VALID), .I_ADDR_TO_AXIM(I_ADDR_TO_AXIM),
    .D_ADDR_TO_AXIM_VALID(D_ADDR_TO_AXIM_VALID), .D_ADDR_TO_AXIM(D_ADDR_TO_AXIM),
    .I_DATA_FROM_AXIM_VALID(I_DATA_FROM_AXIM_VALID), .I_DATA_FROM_AXIM(I_DATA_FROM_AXIM),
    .D_DATA_FROM_AXIM_VALID(D_DATA_FROM_AXIM_VALID), .D_DATA_FROM_AXIM(D_DATA_FROM_AXIM),
    .I_WALK_ERR(I_WALK_ERR), .D_WALK_ERR(D_WALK_ERR),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .OVERRUN(OVERRUN)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    TLB_FLUSH = 0; I_ADDR_TO_AXIM_VALID = 0; D_ADDR_TO_AXIM_VALID = 0;
    I_ADDR_TO_AXIM = 0; D_ADDR_TO_AXIM = 0; M_ARREADY = 0;
    M_RDATA = 0; M_RRESP = 0; M_RLAST = 1; M_RVALID = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1;
    tick();
    tick();
    RST = 0;
  endtask

  // Drive one R beat for the transaction currently in R; response appears after the returned tick.
  task automatic r_beat(input logic [31:0] data, input logic [1:0] resp, input logic last);
    M_RVALID = 1; M_RDATA = data; M_RRESP = resp; M_RLAST = last;
    tick();
    M_RVALID = 0; M_RDATA = 0; M_RRESP = 0; M_RLAST = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    I_ADDR_TO_AXIM_VALID = 1; I_ADDR_TO_AXIM = 32'h1234;
    tick();
    tick();
    RST = 0; I_ADDR_TO_AXIM_VALID = 0;
    tick();
    n_total++;
    if (M_ARVALID !== 1'b0 || M_RREADY !== 1'b0 || M_ARADDR !== 32'h0) begin
      $display("FAIL reset_axi arvalid=%b rready=%b araddr=%h required 0/0/0", M_ARVALID, M_RREADY, M_ARADDR);
    end else n_pass++;
    n_total++;
    if (I_DATA_FROM_AXIM_VALID !== 0 || D_DATA_FROM_AXIM_VALID !== 0 || I_WALK_ERR !== 0 ||
        D_WALK_ERR !== 0 || I_DATA_FROM_AXIM !== 0 || D_DATA_FROM_AXIM !== 0 || OVERRUN !== 0) begin
      $display("FAIL reset_outputs idv=%b ddv=%b ierr=%b derr=%b id=%h dd=%h ovr=%b required all 0",
               I_DATA_FROM_AXIM_VALID, D_DATA_FROM_AXIM_VALID, I_WALK_ERR, D_WALK_ERR,
               I_DATA_FROM_AXIM, D_DATA_FROM_AXIM, OVERRUN);
    end else n_pass++;
    n_total++;
    if (M_ARLEN !== 8'd0 || M_ARSIZE !== 3'b010 || M_ARBURST !== 2'b01) begin
      $display("FAIL ar_consts len=%h size=%b burst=%b required 00/010/01", M_ARLEN, M_ARSIZE, M_ARBURST);
    end else n_pass++;
    tick();
    n_total++;
    if (M_ARVALID !== 1'b0) $display("FAIL reset_req_ignored arvalid=%b required 0", M_ARVALID);
    else n_pass++;
  endtask

  task automatic test_single();
    I_ADDR_TO_AXIM_VALID = 1; I_ADDR_TO_AXIM = 32'h0001_0000; M_ARREADY = 1;
    tick();
    I_ADDR_TO_AXIM_VALID = 0;
    n_total++;
    if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'h0001_0000)
      $display("FAIL single_ar arvalid=%b araddr=%h required 1/00010000", M_ARVALID, M_ARADDR);
    else n_pass++;
    tick();
    M_ARREADY = 0;
    n_total++;
    if (M_RREADY !== 1'b1 || M_ARVALID !== 1'b0)
      $display("FAIL single_r rready=%b arvalid=%b required 1/0", M_RREADY, M_ARVALID);
    else n_pass++;
    tick();
    r_beat(32'h4000, 2'b00, 1'b1);
    n_total++;
    if (I_DATA_FROM_AXIM_VALID !== 1'b1 || I_DATA_FROM_AXIM !== 32'h4000 || I_WALK_ERR !== 1'b0 ||
        D_DATA_FROM_AXIM_VALID !== 1'b0)
      $display("FAIL single_resp idv=%b id=%h ierr=%b ddv=%b required 1/4000/0/0",
               I_DATA_FROM_AXIM_VALID, I_DATA_FROM_AXIM, I_WALK_ERR, D_DATA_FROM_AXIM_VALID);
    else n_pass++;
    n_total++;
    if (M_RREADY !== 1'b0) $display("FAIL single_idle rready=%b required 0", M_RREADY);
    else n_pass++;
    tick();
    n_total++;
    if (I_DATA_FROM_AXIM_VALID !== 1'b0 || I_DATA_FROM_AXIM !== 32'h0)
      $display("FAIL single_pulse_width idv=%b id=%h required 0/0", I_DATA_FROM_AXIM_VALID, I_DATA_FROM_AXIM);
    else n_pass++;
  endtask

  task automatic test_dual();
    I_ADDR_TO_AXIM_VALID = 1; I_ADDR_TO_AXIM = 32'h100;
    D_ADDR_TO_AXIM_VALID = 1; D_ADDR_TO_AXIM = 32'h200;
    M_ARREADY = 1;
    tick();
    I_ADDR_TO_AXIM_VALID = 0; D_ADDR_TO_AXIM_VALID = 0;
    n_total++;
    if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'h100)
      $display("FAIL dual_first_ar arvalid=%b araddr=%h required 1/100", M_ARVALID, M_ARADDR);
    else n_pass++;
    tick();
    r_beat(32'h11, 2'b00, 1'b1);
    n_total++;
    if (I_DATA_FROM_AXIM_VALID !== 1'b1 || I_DATA_FROM_AXIM !== 32'h11 ||
        D_DATA_FROM_AXIM_VALID !== 1'b0 || D_DATA_FROM_AXIM !== 32'h0)
      $display("FAIL dual_first_resp idv=%b id=%h ddv=%b dd=%h required 1/11/0/0",
               I_DATA_FROM_AXIM_VALID, I_DATA_FROM_AXIM, D_DATA_FROM_AXIM_VALID, D_DATA_FROM_AXIM);
    else n_pass++;
    tick();
    n_total++;
    if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'h200)
      $display("FAIL dual_second_ar arvalid=%b araddr=%h required 1/200", M_ARVALID, M_ARADDR);
    else n_pass++;
    tick();
    r_beat(32'h22, 2'b00, 1'b1);
    n_total++;
    if (D_DATA_FROM_AXIM_VALID !== 1'b1 || D_DATA_FROM_AXIM !== 32'h22 || I_DATA_FROM_AXIM_VALID !== 1'b0)
      $display("FAIL dual_second_resp ddv=%b dd=%h idv=%b required 1/22/0",
               D_DATA_FROM_AXIM_VALID, D_DATA_FROM_AXIM, I_DATA_FROM_AXIM_VALID);
    else n_pass++;
    tick();
    // Round-robin pointer now favours D for the next contention.
    I_ADDR_TO_AXIM_VALID = 1; I_ADDR_TO_AXIM = 32'h300;
    D_ADDR_TO_AXIM_VALID = 1; D_ADDR_TO_AXIM = 32'h400;
    tick();
    I_ADDR_TO_AXIM_VALID = 0; D_ADDR_TO_AXIM_VALID = 0;
    n_total++;
    if (M_ARADDR !== 32'h400 || M_ARVALID !== 1'b1)
      $display("FAIL rr_d_first arvalid=%b araddr=%h required 1/400", M_ARVALID, M_ARADDR);
    else n_pass++;
    tick();
    r_beat(32'h44, 2'b00, 1'b1);
    n_total++;
    if (D_DATA_FROM_AXIM_VALID !== 1'b1 || D_DATA_FROM_AXIM !== 32'h44)
      $display("FAIL rr_d_resp ddv=%b dd=%h required 1/44", D_DATA_FROM_AXIM_VALID, D_DATA_FROM_AXIM);
    else n_pass++;
    tick();
    n_total++;
    if (M_ARADDR !== 32'h300 || M_ARVALID !== 1'b1)
      $display("FAIL rr_i_second arvalid=%b araddr=%h required 1/300", M_ARVALID, M_ARADDR);
    else n_pass++;
    tick();
    r_beat(32'h33, 2'b00, 1'b1);
    n_total++;
    if (I_DATA_FROM_AXIM_VALID !== 1'b1 || I_DATA_FROM_AXIM !== 32'h33)
      $display("FAIL rr_i_resp idv=%b id=%h required 1/33", I_DATA_FROM_AXIM_VALID, I_DATA_FROM_AXIM);
    else n_pass++;
    M_ARREADY = 0;
    tick();
  endtask

  task automatic test_stall();
    M_ARREADY = 0;
    I_ADDR_TO_AXIM_VALID = 1; I_ADDR_TO_AXIM = 32'h500;
    tick();
    I_ADDR_TO_AXIM_VALID = 0;
    for (int c = 1; c <= 5; c++) begin
      n_total++;
      if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'h500)
        $display("FAIL stall_hold cycle=%0d arvalid=%b araddr=%h required 1/500", c, M_ARVALID, M_ARADDR);
      else n_pass++;
      if (c == 5) M_ARREADY = 1;
      tick();
    end
    M_ARREADY = 0;
    n_total++;
    if (M_ARVALID !== 1'b0 || M_RREADY !== 1'b1)
      $display("FAIL stall_single_hs arvalid=%b rready=%b required 0/1", M_ARVALID, M_RREADY);
    else n_pass++;
    r_beat(32'h55, 2'b00, 1'b1);
    n_total++;
    if (I_DATA_FROM_AXIM_VALID !== 1'b1 || I_DATA_FROM_AXIM !== 32'h55)
      $display("FAIL stall_resp idv=%b id=%h required 1/55", I_DATA_FROM_AXIM_VALID, I_DATA_FROM_AXIM);
    else n_pass++;
    tick();
  endtask

  task automatic test_err();
    M_ARREADY = 1;
    D_ADDR_TO_AXIM_VALID = 1; D_ADDR_TO_AXIM = 32'h600;
    tick();
    D_ADDR_TO_AXIM_VALID = 0;
    tick();
    r_beat(32'hDEAD, 2'b10, 1'b1);
    n_total++;
    if (D_DATA_FROM_AXIM_VALID !== 1'b1 || D_WALK_ERR !== 1'b1 || D_DATA_FROM_AXIM !== 32'h0 || I_WALK_ERR !== 1'b0)
      $display("FAIL rresp_err ddv=%b derr=%b dd=%h ierr=%b required 1/1/0/0",
               D_DATA_FROM_AXIM_VALID, D_WALK_ERR, D_DATA_FROM_AXIM, I_WALK_ERR);
    else n_pass++;
    tick();
    I_ADDR_TO_AXIM_VALID = 1; I_ADDR_TO_AXIM = 32'h680;
    tick();
    I_ADDR_TO_AXIM_VALID = 0;
    tick();
    r_beat(32'hBEEF, 2'b00, 1'b0);
    n_total++;
    if (I_DATA_FROM_AXIM_VALID !== 1'b1 || I_WALK_ERR !== 1'b1 || I_DATA_FROM_AXIM !== 32'h0 || D_WALK_ERR !== 1'b0)
      $display("FAIL rlast_err idv=%b ierr=%b id=%h derr=%b required 1/1/0/0",
               I_DATA_FROM_AXIM_VALID, I_WALK_ERR, I_DATA_FROM_AXIM, D_WALK_ERR);
    else n_pass++;
    M_ARREADY = 0;
    tick();
  endtask

  task automatic test_same_cycle_accept();
    M_ARREADY = 1;
    I_ADDR_TO_AXIM_VALID = 1; I_ADDR_TO_AXIM = 32'hD00;
    tick();
    I_ADDR_TO_AXIM_VALID = 0;
    tick();
    r_beat(32'h77, 2'b00, 1'b1);
    // Response pulse is visible now; new I request rides the same cycle.
    I_ADDR_TO_AXIM_VALID = 1; I_ADDR_TO_AXIM = 32'hE00;
    tick();
    I_ADDR_TO_AXIM_VALID = 0;
    n_total++;
    if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'hE00 || OVERRUN !== 1'b0)
      $display("FAIL same_cycle_accept arvalid=%b araddr=%h ovr=%b required 1/e00/0", M_ARVALID, M_ARADDR, OVERRUN);
    else n_pass++;
    tick();
    r_beat(32'h78, 2'b00, 1'b1);
    M_ARREADY = 0;
    tick();
  endtask

  task automatic test_flush_coincident();
    TLB_FLUSH = 1;
    I_ADDR_TO_AXIM_VALID = 1; I_ADDR_TO_AXIM = 32'hF00;
    tick();
    TLB_FLUSH = 0; I_ADDR_TO_AXIM_VALID = 0;
    tick();
    n_total++;
    if (M_ARVALID !== 1'b0 || OVERRUN !== 1'b0)
      $display("FAIL flush_coincident arvalid=%b ovr=%b required 0/0", M_ARVALID, OVERRUN);
    else n_pass++;
  endtask

  task automatic test_flush();
    int ar_seen;
    M_ARREADY = 1;
    I_ADDR_TO_AXIM_VALID = 1; I_ADDR_TO_AXIM = 32'h700;
    tick();
    I_ADDR_TO_AXIM_VALID = 0;
    tick();
    M_ARREADY = 0;
    D_ADDR_TO_AXIM_VALID = 1; D_ADDR_TO_AXIM = 32'h800;
    tick();
    D_ADDR_TO_AXIM_VALID = 0;
    TLB_FLUSH = 1;
    tick();
    TLB_FLUSH = 0;
    n_total++;
    if (M_RREADY !== 1'b1) $display("FAIL flush_completes rready=%b required 1", M_RREADY);
    else n_pass++;
    r_beat(32'h99, 2'b00, 1'b1);
    n_total++;
    if (I_DATA_FROM_AXIM_VALID !== 1'b0 || D_DATA_FROM_AXIM_VALID !== 1'b0 || M_RREADY !== 1'b0)
      $display("FAIL flush_suppress idv=%b ddv=%b rready=%b required 0/0/0",
               I_DATA_FROM_AXIM_VALID, D_DATA_FROM_AXIM_VALID, M_RREADY);
    else n_pass++;
    ar_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (M_ARVALID === 1'b1) ar_seen++;
      tick();
    end
    n_total++;
    if (ar_seen != 0) $display("FAIL flush_no_ar ar_cycles=%0d required 0", ar_seen);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int ar_seen;
    do_reset();
    tick();
    M_ARREADY = 0;
    D_ADDR_TO_AXIM_VALID = 1; D_ADDR_TO_AXIM = 32'hA00;
    tick();
    D_ADDR_TO_AXIM_VALID = 0;
    I_ADDR_TO_AXIM_VALID = 1; I_ADDR_TO_AXIM = 32'hB00;
    tick();
    n_total++;
    if (OVERRUN !== 1'b0) $display("FAIL overrun_first_ok ovr=%b required 0", OVERRUN);
    else n_pass++;
    I_ADDR_TO_AXIM = 32'hC00;
    tick();
    I_ADDR_TO_AXIM_VALID = 0;
    n_total++;
    if (OVERRUN !== 1'b1) $display("FAIL overrun_set ovr=%b required 1", OVERRUN);
    else n_pass++;
    M_ARREADY = 1;
    tick();
    r_beat(32'hAA, 2'b00, 1'b1);
    n_total++;
    if (D_DATA_FROM_AXIM_VALID !== 1'b1 || D_DATA_FROM_AXIM !== 32'hAA)
      $display("FAIL overrun_d_resp ddv=%b dd=%h required 1/aa", D_DATA_FROM_AXIM_VALID, D_DATA_FROM_AXIM);
    else n_pass++;
    tick();
    n_total++;
    if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'hB00)
      $display("FAIL overrun_first_addr arvalid=%b araddr=%h required 1/b00", M_ARVALID, M_ARADDR);
    else n_pass++;
    tick();
    r_beat(32'hBB, 2'b00, 1'b1);
    ar_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (M_ARVALID === 1'b1) ar_seen++;
      tick();
    end
    n_total++;
    if (ar_seen != 0 || OVERRUN !== 1'b1)
      $display("FAIL overrun_dropped ar_cycles=%0d ovr=%b required 0/1", ar_seen, OVERRUN);
    else n_pass++;
    do_reset();
    tick();
    n_total++;
    if (OVERRUN !== 1'b0) $display("FAIL overrun_clear ovr=%b required 0", OVERRUN);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_stall();
    test_err();
    test_same_cycle_accept();
    test_flush_coincident();
    test_flush();
    test_overrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tlb_walk_axi_reader.md
TLB_WALK_AXI_READER -- requirements
Module: tlb_walk_axi_reader

Interface
REQ-001 SHALL have parameter ADDR_W, 32, width of walk and AXI read addresses.
REQ-002 SHALL have parameter DATA_W, 32, width of walk and AXI read data.
REQ-003 SHALL have port CLK  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port TLB_FLUSH  in  1  cancel pending walks; suppress in-flight response.
REQ-006 SHALL have ports I_ADDR_TO_AXIM_VALID / D_ADDR_TO_AXIM_VALID  in  1  one-cycle walk-request pulse from ITLB / DTLB.
REQ-007 SHALL have ports I_ADDR_TO_AXIM / D_ADDR_TO_AXIM  in  ADDR_W  walk address, valid with its pulse.
REQ-008 SHALL have ports I_DATA_FROM_AXIM_VALID / D_DATA_FROM_AXIM_VALID  out  1  one-cycle response pulse per client.
REQ-009 SHALL have ports I_DATA_FROM_AXIM / D_DATA_FROM_AXIM  out  DATA_W  response data, valid with its pulse.
REQ-010 SHALL have ports I_WALK_ERR / D_WALK_ERR  out  1  pulse with response when RRESP != OKAY.
REQ-011 SHALL have ports M_ARADDR out ADDR_W, M_ARVALID out 1, M_ARREADY in 1, M_ARLEN out 8, M_ARSIZE out 3, M_ARBURST out 2 (AXI4 read address).
REQ-012 SHALL have ports M_RDATA in DATA_W, M_RRESP in 2, M_RLAST in 1, M_RVALID in 1, M_RREADY out 1 (AXI4 read data).
REQ-013 SHALL have port OVERRUN  out  1  sticky: request arrived while same client already pending.

Function
REQ-014 SHALL drive M_ARLEN=0, M_ARSIZE=3'b010, M_ARBURST=2'b01 constantly.
REQ-015 SHALL latch each client's request into a one-deep pending register (valid flag + address) on its pulse.
REQ-016 SHALL drop a pulse arriving while that client's pending flag is set (or while its walk is in flight) and set OVERRUN.
REQ-017 SHALL implement FSM IDLE -> AR -> R -> IDLE; at most one AXI transaction outstanding.
REQ-018 IDLE: if any pending flag set, select client, load M_ARADDR, clear that pending flag, go AR next cycle.
REQ-019 Arbitration SHALL be round-robin: when both pending, grant client not granted last; after reset, I has priority.
REQ-020 A pulse at cycle N with FSM idle and no other pending SHALL yield M_ARVALID=1 at N+1 (one-cycle latch, one-cycle issue is NOT permitted; ARVALID rises exactly one cycle after the pulse).
REQ-021 AR: M_ARVALID held high, M_ARADDR stable until M_ARVALID&M_ARREADY; then go R.
REQ-022 R: M_RREADY=1 only in R; on M_RVALID&M_RREADY go IDLE.
REQ-023 Handshake at cycle M SHALL produce granted client's DATA_FROM_AXIM_VALID=1 with DATA=M_RDATA at M+1, exactly one cycle.
REQ-024 WALK_ERR SHALL pulse with DATA_VALID when M_RRESP != 2'b00; DATA then forced to 0.
REQ-025 M_RLAST=0 on a beat SHALL be treated as error (WALK_ERR, DATA=0).
REQ-026 Request pulse in same cycle as its client's response pulse SHALL be accepted (not overrun).
REQ-027 Simultaneous I and D pulses SHALL both be latched; served back-to-back per REQ-019.
REQ-028 TLB_FLUSH SHALL clear both pending flags; a transaction in AR or R SHALL complete on AXI with its response pulse suppressed.
REQ-029 Request pulse coincident with TLB_FLUSH SHALL be discarded.
REQ-030 Data/err outputs for non-granted client SHALL stay 0.

Reset
REQ-031 RST SHALL force FSM IDLE, pending flags 0, M_ARVALID=0, M_RREADY=0, all DATA_VALID/WALK_ERR=0, DATA outputs 0, M_ARADDR 0, OVERRUN 0, round-robin to I.
REQ-032 RST mid-AR/R SHALL abandon transaction immediately; requests during RST ignored.

Verification
REQ-033 I pulse addr 0x0001_0000, ARREADY=1, RVALID 2 cycles later data 0x4000, RRESP=0 -> ARVALID at +1, I_DATA_VALID one cycle with 0x4000.
REQ-034 I and D pulse same cycle (0x100, 0x200) -> AR 0x100 then 0x200; I then D responses; next double request grants D first.
REQ-035 ARREADY held low 5 cycles -> ARVALID/ARADDR stable 5 cycles, single handshake.
REQ-036 RRESP=2'b10 -> D_WALK_ERR and D_DATA_VALID same cycle, D_DATA=0.
REQ-037 TLB_FLUSH while in R with D pending -> I response suppressed, D pending cleared, FSM IDLE, no further AR.
REQ-038 Second I pulse while I pending -> OVERRUN=1 until RST; only first address issued.
